// File: rtl/dsp_ar_channel_pkg.sv
// ---------------------------------------------------------------------------
// dsp_ar_channel_pkg
//   Shared definitions for the read/write address dispatchers.
//   - AXI control-field widths (ARLEN/ARBURST/ARSIZE).
//   - ar_ctrl_t: the burst-control fields that travel with an address beat.
//   - slv_decode(): maps the raw top address bits to a slave index. Indices
//     beyond the populated slave range are folded onto the last slave
//     because this block has no DECERR path. The AW dispatcher calls the
//     same function.
// ---------------------------------------------------------------------------
package dsp_ar_channel_pkg;

  localparam int ARLEN_W   = 8;
  localparam int ARBURST_W = 2;
  localparam int ARSIZE_W  = 3;

  typedef struct packed {
    logic [ARLEN_W-1:0]   len;
    logic [ARBURST_W-1:0] burst;
    logic [ARSIZE_W-1:0]  size;
  } ar_ctrl_t;

  // raw_id is the zero-extended slave field taken from the top address bits.
  function automatic logic [31:0] slv_decode(input logic [31:0] raw_id,
                                             input int unsigned slv_amt);
    logic [31:0] id;
    if (raw_id >= slv_amt) begin
      id = slv_amt - 1;
    end else begin
      id = raw_id;
    end
    return id;
  endfunction

endpackage

// File: rtl/dsp_ar_channel_fifo.sv
// ---------------------------------------------------------------------------
// dsp_ar_channel_fifo
//   Synchronous FIFO used as the read-order queue. The head entry is kept in
//   a register (head_o) that always shows the oldest stored word while the
//   FIFO is not empty, so consumers never wait for a read cycle.
// Ports
//   clk      in   clock, rising edge
//   srst     in   synchronous active-high reset (pointers/count/head cleared)
//   push_i   in   write data_i (ignored while full)
//   data_i   in   DATA_WIDTH write data
//   pop_i    in   discard head entry (ignored while empty, asserted illegal)
//   head_o   out  DATA_WIDTH oldest entry, valid while ~empty_o
//   empty_o  out  no entries stored
//   full_o   out  FIFO_DEPTH entries stored
// ---------------------------------------------------------------------------
module dsp_ar_channel_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_o  = head_q;

  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_inc;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Keep the head register pointing at the oldest live word. After a pop
    // the next word is either already in memory (count >= 2) or is the word
    // being pushed right now (count == 1 with a simultaneous push).
    if (pop_ok) begin
      if (count_q > CNT_W'(1)) begin
        head_d = mem_q[rd_ptr_inc];
      end else if (push_ok) begin
        head_d = data_i;
      end
    end else if (push_ok && empty_o) begin
      head_d = data_i;
    end
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // A pop with nothing queued means the R path returned an unrequested burst.
  pop_when_empty_a : assert property (@(posedge clk) disable iff (srst)
                                      !(pop_i && empty_o));

endmodule

// File: rtl/dsp_ar_channel.sv
// ---------------------------------------------------------------------------
// dsp_ar_channel
//   Per-master read-address dispatcher. Decodes ARADDR to a slave index,
//   forwards the AR beat through a one-entry register slice to the selected
//   slave arbiter, and records every accepted slave index in an in-order
//   queue whose head steers the RDATA return mux.
// Ports
//   ACLK_i / ARESET_i      clock, synchronous active-high reset
//   m_AR*_i, m_ARREADY_o   master-side AR channel
//   sa_AR*_o               AR payload shared by all slave arbiters
//   sa_ARVALID_o           one-hot valid, only the decoded slave's bit
//   sa_ARREADY_i           per-slave ready
//   m_RLAST_i              RLAST at the master R port
//   dsp_R_handshake_i      R handshake pulse from the RDATA dispatcher
//   dsp_AR_slv_id_o        slave index of the oldest outstanding burst
//   dsp_AR_disable_o       1 when no burst is outstanding
// ---------------------------------------------------------------------------
module dsp_ar_channel
  import dsp_ar_channel_pkg::*;
#(
  parameter int SLV_AMT        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int TRANS_MST_ID_W = 5,
  parameter int SLV_ID_W       = $clog2(SLV_AMT),
  parameter int OUTST_AMT      = 4
) (
  input  logic                      ACLK_i,
  input  logic                      ARESET_i,
  input  logic [TRANS_MST_ID_W-1:0] m_ARID_i,
  input  logic [ADDR_WIDTH-1:0]     m_ARADDR_i,
  input  logic [ARLEN_W-1:0]        m_ARLEN_i,
  input  logic [ARBURST_W-1:0]      m_ARBURST_i,
  input  logic [ARSIZE_W-1:0]       m_ARSIZE_i,
  input  logic                      m_ARVALID_i,
  output logic                      m_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0] sa_ARID_o,
  output logic [ADDR_WIDTH-1:0]     sa_ARADDR_o,
  output logic [ARLEN_W-1:0]        sa_ARLEN_o,
  output logic [ARBURST_W-1:0]      sa_ARBURST_o,
  output logic [ARSIZE_W-1:0]       sa_ARSIZE_o,
  output logic [SLV_AMT-1:0]        sa_ARVALID_o,
  input  logic [SLV_AMT-1:0]        sa_ARREADY_i,
  input  logic                      m_RLAST_i,
  input  logic                      dsp_R_handshake_i,
  output logic [SLV_ID_W-1:0]       dsp_AR_slv_id_o,
  output logic                      dsp_AR_disable_o
);

  // ---------------- address decode ----------------
  logic [SLV_ID_W-1:0] dec_id;

  assign dec_id = SLV_ID_W'(slv_decode(32'(m_ARADDR_i[ADDR_WIDTH-1 -: SLV_ID_W]),
                                       SLV_AMT));

  // ---------------- register slice ----------------
  logic                      slice_vld_q,  slice_vld_d;
  logic [SLV_ID_W-1:0]       slice_id_q,   slice_id_d;
  logic [TRANS_MST_ID_W-1:0] slice_arid_q, slice_arid_d;
  logic [ADDR_WIDTH-1:0]     slice_addr_q, slice_addr_d;
  ar_ctrl_t                  slice_ctrl_q, slice_ctrl_d;

  logic slice_drain;
  logic mst_hs;
  logic q_full;
  logic q_pop;

  // Drain uses only registered slice state plus the slave ready, so valid
  // itself never depends on ready.
  assign slice_drain = slice_vld_q & sa_ARREADY_i[slice_id_q];

  // Ready looks at the registered full flag only; a pop in the same cycle
  // does not open the door until the following cycle.
  assign m_ARREADY_o = (~slice_vld_q | slice_drain) & ~q_full;
  assign mst_hs      = m_ARVALID_i & m_ARREADY_o;
  assign q_pop       = dsp_R_handshake_i & m_RLAST_i;

  always_comb begin
    slice_vld_d  = slice_vld_q;
    slice_id_d   = slice_id_q;
    slice_arid_d = slice_arid_q;
    slice_addr_d = slice_addr_q;
    slice_ctrl_d = slice_ctrl_q;

    // Loading takes priority over draining so a beat can enter in the same
    // cycle the previous one leaves (one AR per cycle). Payload only changes
    // on a load, which keeps it stable while waiting for ready.
    if (mst_hs) begin
      slice_vld_d        = 1'b1;
      slice_id_d         = dec_id;
      slice_arid_d       = m_ARID_i;
      slice_addr_d       = m_ARADDR_i;
      slice_ctrl_d.len   = m_ARLEN_i;
      slice_ctrl_d.burst = m_ARBURST_i;
      slice_ctrl_d.size  = m_ARSIZE_i;
    end else if (slice_drain) begin
      slice_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      slice_vld_q  <= 1'b0;
      slice_id_q   <= '0;
      slice_arid_q <= '0;
      slice_addr_q <= '0;
      slice_ctrl_q <= '0;
    end else begin
      slice_vld_q  <= slice_vld_d;
      slice_id_q   <= slice_id_d;
      slice_arid_q <= slice_arid_d;
      slice_addr_q <= slice_addr_d;
      slice_ctrl_q <= slice_ctrl_d;
    end
  end

  assign sa_ARID_o    = slice_arid_q;
  assign sa_ARADDR_o  = slice_addr_q;
  assign sa_ARLEN_o   = slice_ctrl_q.len;
  assign sa_ARBURST_o = slice_ctrl_q.burst;
  assign sa_ARSIZE_o  = slice_ctrl_q.size;

  generate
    for (genvar gi = 0; gi < SLV_AMT; gi++) begin : g_valid
      assign sa_ARVALID_o[gi] = slice_vld_q & (slice_id_q == SLV_ID_W'(gi));
    end
  endgenerate

  // ---------------- read-order queue ----------------
  logic q_empty;

  dsp_ar_channel_fifo #(
    .DATA_WIDTH (SLV_ID_W),
    .FIFO_DEPTH (OUTST_AMT)
  ) u_order_q (
    .clk     (ACLK_i),
    .srst    (ARESET_i),
    .push_i  (mst_hs),
    .data_i  (dec_id),
    .pop_i   (q_pop),
    .head_o  (dsp_AR_slv_id_o),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign dsp_AR_disable_o = q_empty;

endmodule

// File: tb/tb_dsp_ar_channel.sv
module tb_dsp_ar_channel;

  localparam int SLV_AMT        = 2;
  localparam int ADDR_WIDTH     = 32;
  localparam int TRANS_MST_ID_W = 5;
  localparam int SLV_ID_W       = 1;
  localparam int OUTST_AMT      = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [TRANS_MST_ID_W-1:0] m_arid;
  logic [ADDR_WIDTH-1:0]     m_araddr;
  logic [7:0]                m_arlen;
  logic [1:0]                m_arburst;
  logic [2:0]                m_arsize;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [TRANS_MST_ID_W-1:0] sa_arid;
  logic [ADDR_WIDTH-1:0]     sa_araddr;
  logic [7:0]                sa_arlen;
  logic [1:0]                sa_arburst;
  logic [2:0]                sa_arsize;
  logic [SLV_AMT-1:0]        sa_arvalid;
  logic [SLV_AMT-1:0]        sa_arready;
  logic                      rlast;
  logic                      r_hs;
  logic [SLV_ID_W-1:0]       slv_id;
  logic                      disable_o;

  int passed = 0;
  int total  = 0;
  int sb[$];

  always #5 clk = ~clk;

  dsp_ar_channel #(
    .SLV_AMT        (SLV_AMT),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TRANS_MST_ID_W (TRANS_MST_ID_W),
    .SLV_ID_W       (SLV_ID_W),
    .OUTST_AMT      (OUTST_AMT)
  ) dut (
    .ACLK_i            (clk),
    .ARESET_i          (rst),
    .m_ARID_i          (m_arid),
    .m_ARADDR_i        (m_araddr),
    .m_ARLEN_i         (m_arlen),
    .m_ARBURST_i       (m_arburst),
    .m_ARSIZE_i        (m_arsize),
    .m_ARVALID_i       (m_arvalid),
    .m_ARREADY_o       (m_arready),
    .sa_ARID_o         (sa_arid),
    .sa_ARADDR_o       (sa_araddr),
    .sa_ARLEN_o        (sa_arlen),
    .sa_ARBURST_o      (sa_arburst),
    .sa_ARSIZE_o       (sa_arsize),
    .sa_ARVALID_o      (sa_arvalid),
    .sa_ARREADY_i      (sa_arready),
    .m_RLAST_i         (rlast),
    .dsp_R_handshake_i (r_hs),
    .dsp_AR_slv_id_o   (slv_id),
    .dsp_AR_disable_o  (disable_o)
  );

  // Reference decode: top address bits, clamped to the last slave.
  function automatic int exp_id(input logic [31:0] addr);
    int raw;
    raw = int'(addr >> (32 - SLV_ID_W));
    if (raw >= SLV_AMT) raw = SLV_AMT - 1;
    return raw;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one AR beat until accepted (bounded), record expected slave id.
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len);
    m_araddr  = addr;
    m_arlen   = len;
    m_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (m_arready === 1'b1) begin
        sb.push_back(exp_id(addr));
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        $display("AR  addr=0x%08h len=%0d -> slave %0d (queued=%0d)", addr, len, exp_id(addr), sb.size());
        return;
      end
      @(posedge clk); #1;
    end
    check("ar_accept_timeout", 32'(m_arready), 32'd1);
    m_arvalid = 1'b0;
  endtask

  // Return one burst of len+1 beats; head must hold until RLAST.
  task automatic r_burst(input int len);
    for (int b = 0; b <= len; b++) begin
      r_hs  = 1'b1;
      rlast = (b == len);
      #1;
      check("head_during_burst", 32'(slv_id), 32'(sb[0]));
      check("disable_during_burst", 32'(disable_o), 32'd0);
      @(posedge clk); #1;
    end
    void'(sb.pop_front());
    r_hs  = 1'b0;
    rlast = 1'b0;
    #1;
    check("disable_after_burst", 32'(disable_o), 32'(sb.size() == 0));
    if (sb.size() != 0) check("head_after_burst", 32'(slv_id), 32'(sb[0]));
    $display("R   burst len=%0d done (queued=%0d)", len, sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arburst = '0;
    m_arsize = '0; m_arvalid = 1'b0; sa_arready = '0; rlast = 1'b0; r_hs = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1. reset / idle
    check("idle_arready", 32'(m_arready), 32'd1);
    check("idle_arvalid", 32'(sa_arvalid), 32'd0);
    check("idle_disable", 32'(disable_o), 32'd1);
    check("idle_slv_id", 32'(slv_id), 32'd0);
    check("idle_araddr", sa_araddr, 32'd0);
    $display("T1  reset/idle checked");

    // 2. single AR to slave 1, one-cycle latency, one-cycle valid
    sa_arready = 2'b10;
    m_araddr = 32'h8000_0000; m_arlen = 8'd0; m_arvalid = 1'b1;
    #1;
    check("t2_arready", 32'(m_arready), 32'd1);
    @(posedge clk); #1;
    sb.push_back(exp_id(32'h8000_0000));
    m_arvalid = 1'b0;
    #1;
    check("t2_arvalid", 32'(sa_arvalid), 32'b10);
    check("t2_araddr", sa_araddr, 32'h8000_0000);
    check("t2_head", 32'(slv_id), 32'd1);
    check("t2_disable", 32'(disable_o), 32'd0);
    @(posedge clk); #1;
    check("t2_arvalid_drop", 32'(sa_arvalid), 32'd0);
    $display("T2  single AR to slave 1");
    r_burst(0);

    // 3. slaves 0,1,0 then three 4-beat bursts
    sa_arready = 2'b11;
    ar_issue(32'h0000_1000, 8'd3);
    ar_issue(32'h8000_2000, 8'd3);
    ar_issue(32'h4000_0000, 8'd3);
    for (int k = 0; k < 3; k++) r_burst(3);
    check("t3_disable_end", 32'(disable_o), 32'd1);

    // 4. fill queue, 5th AR stalls, ready back one cycle after RLAST
    ar_issue(32'h8000_0100, 8'd0);
    ar_issue(32'h0000_0200, 8'd0);
    ar_issue(32'h8000_0300, 8'd0);
    ar_issue(32'hC000_0400, 8'd0);
    m_araddr = 32'h8000_0040; m_arvalid = 1'b1;
    #1;
    check("t4_full_stall", 32'(m_arready), 32'd0);
    @(posedge clk); #1; #1;
    check("t4_full_stall2", 32'(m_arready), 32'd0);
    r_hs = 1'b1; rlast = 1'b1;
    #1;
    check("t4_no_bypass", 32'(m_arready), 32'd0);
    @(posedge clk); #1;
    void'(sb.pop_front());
    r_hs = 1'b0; rlast = 1'b0;
    #1;
    check("t4_ready_back", 32'(m_arready), 32'd1);
    check("t4_head", 32'(slv_id), 32'(sb[0]));
    @(posedge clk); #1;
    sb.push_back(exp_id(32'h8000_0040));
    m_arvalid = 1'b0;
    $display("T4  full-queue stall released");
    for (int k = 0; k < 4; k++) r_burst(0);

    // 5. slave not ready: payload stable, ready low, then 1 AR/cycle
    sa_arready = 2'b00;
    m_arid = 5'd5; m_arburst = 2'd1; m_arsize = 3'd2;
    ar_issue(32'h1234_5678, 8'd7);
    m_arid = 5'd9; m_arburst = 2'd2; m_arsize = 3'd1;
    m_araddr = 32'h8765_4320; m_arlen = 8'd2; m_arvalid = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("t5_hold_valid", 32'(sa_arvalid), 32'b01);
      check("t5_hold_addr", sa_araddr, 32'h1234_5678);
      check("t5_hold_len", 32'(sa_arlen), 32'd7);
      check("t5_hold_ready", 32'(m_arready), 32'd0);
      @(posedge clk); #1;
    end
    check("t5_arid", 32'(sa_arid), 32'd5);
    check("t5_arburst", 32'(sa_arburst), 32'd1);
    check("t5_arsize", 32'(sa_arsize), 32'd2);
    sa_arready = 2'b11;
    #1;
    check("t5_release_ready", 32'(m_arready), 32'd1);
    @(posedge clk); #1;
    sb.push_back(exp_id(32'h8765_4320));
    m_araddr = 32'h0000_0010; m_arlen = 8'd0;
    #1;
    check("t5_b_valid", 32'(sa_arvalid), 32'b10);
    check("t5_b_addr", sa_araddr, 32'h8765_4320);
    check("t5_b_arid", 32'(sa_arid), 32'd9);
    check("t5_b_ready", 32'(m_arready), 32'd1);
    @(posedge clk); #1;
    sb.push_back(exp_id(32'h0000_0010));
    m_arvalid = 1'b0;
    #1;
    check("t5_c_valid", 32'(sa_arvalid), 32'b01);
    check("t5_c_addr", sa_araddr, 32'h0000_0010);
    @(posedge clk); #1;
    check("t5_idle_valid", 32'(sa_arvalid), 32'd0);
    $display("T5  backpressure and back-to-back");

    // 6. push + RLAST pop in the same cycle with two queued
    r_burst(0);
    m_araddr = 32'h8000_0000; m_arlen = 8'd0; m_arvalid = 1'b1;
    r_hs = 1'b1; rlast = 1'b1;
    #1;
    check("t6_ready", 32'(m_arready), 32'd1);
    check("t6_head_before", 32'(slv_id), 32'(sb[0]));
    @(posedge clk); #1;
    void'(sb.pop_front());
    sb.push_back(exp_id(32'h8000_0000));
    m_arvalid = 1'b0; r_hs = 1'b0; rlast = 1'b0;
    #1;
    check("t6_head_after", 32'(slv_id), 32'(sb[0]));
    check("t6_disable", 32'(disable_o), 32'd0);
    $display("T6  simultaneous push/pop (queued=%0d)", sb.size());
    r_burst(0);
    r_burst(0);

    // 7. reset mid-burst with three outstanding
    ar_issue(32'h0000_0000, 8'd3);
    ar_issue(32'h8000_0000, 8'd3);
    @(posedge clk); #1;
    sa_arready = 2'b00;
    ar_issue(32'h4000_0000, 8'd3);
    #1;
    check("t7_slice_held", 32'(sa_arvalid), 32'b01);
    r_hs = 1'b1; rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t7_head_mid", 32'(slv_id), 32'(sb[0]));
    r_hs = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check("t7_rst_disable", 32'(disable_o), 32'd1);
    check("t7_rst_arvalid", 32'(sa_arvalid), 32'd0);
    check("t7_rst_slv_id", 32'(slv_id), 32'd0);
    check("t7_rst_araddr", sa_araddr, 32'd0);
    rst = 1'b0; sa_arready = 2'b11;
    @(posedge clk); #1;
    $display("T7  reset mid-burst");
    ar_issue(32'h8000_0000, 8'd1);
    #1;
    check("t7_post_head", 32'(slv_id), 32'd1);
    r_burst(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
